// File: rtl/core_pkg.sv
// core_pkg
//   Shared definitions for the instruction-fetch front end.
//   XLEN / ILEN          : address and instruction widths
//   RESET_PC_DEFAULT     : default first fetch address after reset
//   pc_gen_state_e       : fetch sequencer states
//   align_target()       : clears the low two bits of a redirect target
package core_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;

    // REQ  : request outstanding on the bus, waiting for grant
    // WAIT : request granted, waiting for the response
    // HOLD : instruction presented to decode, waiting for acceptance
    // DROP : a granted request was made stale by a redirect; swallow its response
    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2,
        ST_DROP = 2'd3
    } pc_gen_state_e;

    function automatic logic [XLEN-1:0] align_target(input logic [XLEN-1:0] target);
        return {target[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_hold_reg.sv
// if_hold_reg
//   Output holding register between fetch and decode.
//   clk, rst_n     : clock, asynchronous active-low reset
//   load_i         : capture pc_i / instr_i and raise valid
//   clear_i        : drop valid (wins over load_i); pc/instr keep last value
//   pc_i, instr_i  : data to capture
//   valid_o, pc_o, instr_o : held outputs
module if_hold_reg
    import core_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_i,
    input  logic            clear_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [ILEN-1:0] instr_i,
    output logic            valid_o,
    output logic [XLEN-1:0] pc_o,
    output logic [ILEN-1:0] instr_o
);

    logic            valid_q, valid_d;
    logic [XLEN-1:0] pc_q,    pc_d;
    logic [ILEN-1:0] instr_q, instr_d;

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        if (clear_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            pc_d    = pc_i;
            instr_d = instr_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            instr_q <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign instr_o = instr_q;

endmodule

// File: rtl/pc_gen.sv
// pc_gen
//   Program-counter generator and single-outstanding instruction fetch unit.
//   clk, rst_n                  : clock, asynchronous active-low reset
//   br_taken_i, br_target_i     : redirect pulse and target (low bits forced to 0)
//   imem_req_o, imem_addr_o     : fetch request and address
//   imem_gnt_i                  : request accepted
//   imem_rvalid_i, imem_rdata_i : fetch response
//   if_valid_o, if_pc_o, if_instr_o : instruction presented to decode
//   if_ready_i                  : decode accepts the presented instruction
//   misalign_o                  : one-cycle pulse after a redirect to a misaligned target
module pc_gen
    import core_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            br_taken_i,
    input  logic [XLEN-1:0] br_target_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [ILEN-1:0] imem_rdata_i,
    output logic            if_valid_o,
    output logic [XLEN-1:0] if_pc_o,
    output logic [ILEN-1:0] if_instr_o,
    input  logic            if_ready_i,
    output logic            misalign_o
);

    pc_gen_state_e   state_q,    state_d;
    logic [XLEN-1:0] pc_q,       pc_d;
    logic [XLEN-1:0] inflight_q, inflight_d;
    logic            misalign_q, misalign_d;
    logic            hold_load;
    logic            hold_clear;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        inflight_d = inflight_q;
        misalign_d = 1'b0;
        hold_load  = 1'b0;
        hold_clear = 1'b0;

        if (br_taken_i) begin
            // A redirect overrides everything; the only state-dependent
            // question is whether a fetch is (or just became) outstanding
            // and therefore has a response that must be swallowed.
            pc_d       = align_target(br_target_i);
            misalign_d = |br_target_i[1:0];
            hold_clear = 1'b1;
            unique case (state_q)
                ST_REQ:  state_d = imem_gnt_i    ? ST_DROP : ST_REQ;
                ST_WAIT: state_d = imem_rvalid_i ? ST_REQ  : ST_DROP;
                ST_HOLD: state_d = ST_REQ;
                ST_DROP: state_d = ST_DROP;
                default: state_d = ST_REQ;
            endcase
        end else begin
            unique case (state_q)
                ST_REQ: begin
                    if (imem_gnt_i) begin
                        inflight_d = pc_q;
                        pc_d       = pc_q + XLEN'(4);  // wraps modulo 2^XLEN
                        state_d    = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem_rvalid_i) begin
                        hold_load = 1'b1;
                        state_d   = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (if_ready_i) begin
                        hold_clear = 1'b1;
                        state_d    = ST_REQ;
                    end
                end
                ST_DROP: begin
                    if (imem_rvalid_i) begin
                        state_d = ST_REQ;
                    end
                end
                default: state_d = ST_REQ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_REQ;
            pc_q       <= RESET_PC;
            inflight_q <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            misalign_q <= misalign_d;
        end
    end

    if_hold_reg u_if_hold_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (hold_load),
        .clear_i (hold_clear),
        .pc_i    (inflight_q),
        .instr_i (imem_rdata_i),
        .valid_o (if_valid_o),
        .pc_o    (if_pc_o),
        .instr_o (if_instr_o)
    );

    // State resets to REQ, so the request is additionally gated by rst_n to
    // keep the bus quiet while reset is held.
    assign imem_req_o  = rst_n && (state_q == ST_REQ);
    assign imem_addr_o = pc_q;
    assign misalign_o  = misalign_q;

endmodule

// File: tb/tb_pc_gen.sv
module tb_pc_gen;

    localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        br_taken_i = 1'b0;
    logic [63:0] br_target_i = '0;
    logic        imem_req_o;
    logic [63:0] imem_addr_o;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic        if_valid_o;
    logic [63:0] if_pc_o;
    logic [31:0] if_instr_o;
    logic        if_ready_i = 1'b0;
    logic        misalign_o;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    pc_gen dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .br_taken_i    (br_taken_i),
        .br_target_i   (br_target_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .if_valid_o    (if_valid_o),
        .if_pc_o       (if_pc_o),
        .if_instr_o    (if_instr_o),
        .if_ready_i    (if_ready_i),
        .misalign_o    (misalign_o)
    );

    // Reference model: tracks "is a fetch outstanding", "will its response be
    // thrown away", "is an instruction sitting at decode" as plain flags.
    logic [63:0] m_pc, m_inflight, m_opc;
    logic [31:0] m_oinstr;
    logic        m_outst, m_discard, m_held, m_mis;

    logic [63:0] issued_q[$];
    logic [63:0] presented_q[$];

    task automatic model_reset();
        m_pc = RST_PC; m_inflight = '0; m_opc = '0; m_oinstr = '0;
        m_outst = 1'b0; m_discard = 1'b0; m_held = 1'b0; m_mis = 1'b0;
    endtask

    task automatic model_update(input logic br, input logic [63:0] tgt, input logic gnt,
                                input logic rv, input logic [31:0] rd, input logic rdy);
        if (br) begin
            m_mis = (tgt[1:0] != 2'b00);
            if (m_held) m_held = 1'b0;
            else if (!m_outst) begin
                if (gnt) begin m_outst = 1'b1; m_discard = 1'b1; end
            end else if (!m_discard) begin
                if (rv) m_outst = 1'b0; else m_discard = 1'b1;
            end
            m_pc = tgt & ~64'd3;
        end else begin
            m_mis = 1'b0;
            if (m_held) begin
                if (rdy) m_held = 1'b0;
            end else if (!m_outst) begin
                if (gnt) begin
                    m_inflight = m_pc; m_pc = m_pc + 64'd4;
                    m_outst = 1'b1; m_discard = 1'b0;
                end
            end else if (m_discard) begin
                if (rv) begin m_outst = 1'b0; m_discard = 1'b0; end
            end else if (rv) begin
                m_outst = 1'b0; m_held = 1'b1; m_opc = m_inflight; m_oinstr = rd;
            end
        end
    endtask

    function automatic logic [162:0] dut_vec();
        return {imem_req_o, imem_addr_o, if_valid_o, if_pc_o, if_instr_o, misalign_o};
    endfunction

    function automatic logic [162:0] exp_vec();
        logic r;
        r = !m_outst && !m_held;
        return {r, m_pc, m_held, m_opc, m_oinstr, m_mis};
    endfunction

    // Drive one cycle of inputs, record bus/decode handshakes seen before the
    // edge, clock, advance the model; returns #1 after the edge.
    task automatic step(input logic br, input logic [63:0] tgt, input logic gnt,
                        input logic rv, input logic [31:0] rd, input logic rdy);
        br_taken_i = br; br_target_i = tgt; imem_gnt_i = gnt;
        imem_rvalid_i = rv; imem_rdata_i = rd; if_ready_i = rdy;
        #3;
        if (imem_req_o && gnt && !br) issued_q.push_back(imem_addr_o);
        if (if_valid_o && rdy && !br) presented_q.push_back(if_pc_o);
        @(posedge clk);
        model_update(br, tgt, gnt, rv, rd, rdy);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({imem_req_o, if_valid_o, if_pc_o, if_instr_o, misalign_o} !== '0) begin
            n_mis++;
            $display("FAIL reset_outputs: got req=%0b v=%0b pc=%h ins=%h mis=%0b want all 0",
                     imem_req_o, if_valid_o, if_pc_o, if_instr_o, misalign_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== RST_PC) begin
            n_mis++;
            $display("FAIL reset_release: got req=%0b addr=%h want req=1 addr=%h",
                     imem_req_o, imem_addr_o, RST_PC);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_sequential();
        logic [63:0] exp_a;
        issued_q.delete(); presented_q.delete();
        for (int i = 0; i < 9; i++) begin
            step(1'b0, '0, 1'b1, 1'b1, 32'h1000_0000 + 32'(i), 1'b1);
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_mis++;
                $display("FAIL seq_step%0d: got %h want %h", i, dut_vec(), exp_vec());
            end
        end
        for (int i = 0; i < 3; i++) begin
            exp_a = RST_PC + 64'(4 * i);
            n_cmp++;
            if (issued_q.size() <= i || issued_q[i] !== exp_a) begin
                n_mis++;
                $display("FAIL seq_issue%0d: got %h want %h", i,
                         (issued_q.size() > i) ? issued_q[i] : 64'hx, exp_a);
            end
            n_cmp++;
            if (presented_q.size() <= i || presented_q[i] !== exp_a) begin
                n_mis++;
                $display("FAIL seq_present%0d: got %h want %h", i,
                         (presented_q.size() > i) ? presented_q[i] : 64'hx, exp_a);
            end
        end
    endtask

    task automatic test_hold_stall();
        logic [63:0] pc0;
        logic [31:0] in0;
        step(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1, 32'hCAFE_F00D, 1'b0);
        pc0 = if_pc_o; in0 = if_instr_o;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, '0, 1'b1, 1'b1, 32'h0BAD_0BAD, 1'b0);
            n_cmp++;
            if (imem_req_o !== 1'b0 || if_valid_o !== 1'b1 || if_pc_o !== m_opc ||
                if_pc_o !== pc0 || if_instr_o !== in0 || in0 !== 32'hCAFE_F00D) begin
                n_mis++;
                $display("FAIL hold_stall%0d: got req=%0b v=%0b pc=%h ins=%h want req=0 v=1 pc=%h ins=cafef00d",
                         i, imem_req_o, if_valid_o, if_pc_o, if_instr_o, m_opc);
            end
        end
        step(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
        n_cmp++;
        if (dut_vec() !== exp_vec()) begin
            n_mis++;
            $display("FAIL hold_release: got %h want %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_redirect_wait();
        step(1'b0, '0, 1'b1, 1'b0, '0, 1'b1);
        step(1'b1, 64'h1000, 1'b0, 1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0, '0, 1'b1);
        n_cmp++;
        if (imem_req_o !== 1'b0 || if_valid_o !== 1'b0) begin
            n_mis++;
            $display("FAIL redir_wait_drop: got req=%0b v=%0b want 0 0", imem_req_o, if_valid_o);
        end
        step(1'b0, '0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1);
        n_cmp++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 64'h1000 || if_valid_o !== 1'b0) begin
            n_mis++;
            $display("FAIL redir_wait_next: got req=%0b addr=%h v=%0b want 1 1000 0",
                     imem_req_o, imem_addr_o, if_valid_o);
        end
        n_cmp++;
        if (dut_vec() !== exp_vec()) begin
            n_mis++;
            $display("FAIL redir_wait_model: got %h want %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_redirect_grant_misalign();
        step(1'b1, 64'h2002, 1'b1, 1'b0, '0, 1'b1);
        n_cmp++;
        if (misalign_o !== 1'b1 || imem_req_o !== 1'b0 || imem_addr_o !== 64'h2000) begin
            n_mis++;
            $display("FAIL redir_gnt: got mis=%0b req=%0b addr=%h want 1 0 2000",
                     misalign_o, imem_req_o, imem_addr_o);
        end
        step(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
        n_cmp++;
        if (misalign_o !== 1'b0 || imem_req_o !== 1'b0) begin
            n_mis++;
            $display("FAIL redir_gnt_pulse: got mis=%0b req=%0b want 0 0", misalign_o, imem_req_o);
        end
        step(1'b0, '0, 1'b0, 1'b1, 32'h1111_2222, 1'b1);
        n_cmp++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 64'h2000 || if_valid_o !== 1'b0) begin
            n_mis++;
            $display("FAIL redir_gnt_next: got req=%0b addr=%h v=%0b want 1 2000 0",
                     imem_req_o, imem_addr_o, if_valid_o);
        end
    endtask

    task automatic test_wrap();
        step(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1, 32'h7777_0000, 1'b0);
        n_cmp++;
        if (if_valid_o !== 1'b1 || if_pc_o !== 64'hFFFF_FFFF_FFFF_FFFC) begin
            n_mis++;
            $display("FAIL wrap_present: got v=%0b pc=%h want 1 fffffffffffffffc", if_valid_o, if_pc_o);
        end
        step(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
        n_cmp++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 64'h0) begin
            n_mis++;
            $display("FAIL wrap_addr: got req=%0b addr=%h want 1 0", imem_req_o, imem_addr_o);
        end
    endtask

    task automatic test_async_reset();
        step(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1, 32'h5A5A_5A5A, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
        imem_gnt_i = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({imem_req_o, if_valid_o, if_pc_o, if_instr_o, misalign_o} !== '0 || imem_addr_o !== RST_PC) begin
            n_mis++;
            $display("FAIL async_reset: got req=%0b addr=%h v=%0b pc=%h ins=%h want 0 %h 0 0 0",
                     imem_req_o, imem_addr_o, if_valid_o, if_pc_o, if_instr_o, RST_PC);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, '0, 1'b0, 1'b1, 32'hEEEE_EEEE, 1'b1);
        n_cmp++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== RST_PC || if_valid_o !== 1'b0) begin
            n_mis++;
            $display("FAIL async_release: got req=%0b addr=%h v=%0b want 1 %h 0",
                     imem_req_o, imem_addr_o, if_valid_o, RST_PC);
        end
    endtask

    task automatic test_random();
        logic        br;
        logic [63:0] tgt;
        for (int i = 0; i < 3000; i++) begin
            br  = ($urandom_range(0, 7) == 0);
            tgt = {$urandom(), $urandom()};
            if ($urandom_range(0, 3) == 0) tgt = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
            step(br, tgt, 1'($urandom()), 1'($urandom()), $urandom(), 1'($urandom()));
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_mis++;
                $display("FAIL random_cyc%0d: got %h want %h", i, dut_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_hold_stall();
        test_redirect_wait();
        test_redirect_grant_misalign();
        test_wrap();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter: RESET_PC, default 64'h0000_0000_8000_0000, first fetch address after reset.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 br_taken_i  input  1  redirect request, one-cycle pulse.
REQ-005 br_target_i  input  64  redirect target (branch adder sum pccurrent+pcoffset).
REQ-006 imem_req_o  output  1  fetch request valid.
REQ-007 imem_addr_o  output  64  fetch address.
REQ-008 imem_gnt_i  input  1  request accepted this cycle.
REQ-009 imem_rvalid_i  input  1  fetch response valid.
REQ-010 imem_rdata_i  input  32  fetched instruction.
REQ-011 if_valid_o  output  1  instruction valid to decode.
REQ-012 if_pc_o  output  64  PC of presented instruction; feeds branch adder pccurrent.
REQ-013 if_instr_o  output  32  presented instruction.
REQ-014 if_ready_i  input  1  decode accepts instruction.
REQ-015 misalign_o  output  1  one-cycle pulse, redirect target had bits [1:0] != 0.

Function
REQ-016 States SHALL be REQ, WAIT, HOLD, DROP; at most one outstanding fetch.
REQ-017 REQ: imem_req_o=1, imem_addr_o=pc_q; address held stable until grant or redirect.
REQ-018 REQ with imem_gnt_i: inflight_pc<=pc_q, pc_q<=pc_q+4, next state WAIT.
REQ-019 WAIT with imem_rvalid_i: output register loads {inflight_pc, imem_rdata_i}, if_valid_o=1 from next cycle, next state HOLD.
REQ-020 HOLD: outputs stable; with if_ready_i, if_valid_o clears next cycle, next state REQ (no bubble beyond one cycle).
REQ-021 pc_q+4 SHALL wrap modulo 2^64 (64'hFFFF_FFFF_FFFF_FFFC -> 0).
REQ-022 br_taken_i SHALL take priority over every other event in every state.
REQ-023 Redirect: pc_q<={br_target_i[63:2],2'b00}; if_valid_o cleared next cycle.
REQ-024 Redirect in REQ without grant -> REQ; with grant same cycle -> DROP.
REQ-025 Redirect in WAIT without rvalid -> DROP; with rvalid same cycle -> response discarded, -> REQ.
REQ-026 Redirect in HOLD (with or without if_ready_i) -> REQ; held instruction discarded.
REQ-027 Redirect in DROP -> DROP, pc_q updated.
REQ-028 DROP: imem_req_o=0; imem_rvalid_i discards response, -> REQ.
REQ-029 misalign_o SHALL pulse one cycle after a redirect with br_target_i[1:0]!=0.
REQ-030 imem_req_o SHALL be 0 in WAIT, HOLD, DROP.

Reset
REQ-031 On rst_n low, immediately: state=REQ, pc_q=RESET_PC, inflight_pc=0, if_valid_o=0, if_pc_o=0, if_instr_o=0, misalign_o=0.
REQ-032 imem_req_o SHALL be 0 while rst_n is low and 1 with imem_addr_o=RESET_PC on the first cycle after release.
REQ-033 Reset mid-fetch SHALL abandon the outstanding request; stale responses after release are the memory's responsibility.

Structure
REQ-034 Shared package core_pkg SHALL hold XLEN=64, ILEN=32, RESET_PC default, and the pc_gen_state_e enum.
REQ-035 Output holding register SHALL be a sub-module if_hold_reg (load, clear, hold of pc/instr/valid).
REQ-036 No other sub-modules; the +4 incrementer is inline.

Verification
REQ-037 Reset release, gnt/rvalid one cycle each, if_ready_i=1 -> addresses 0x80000000, 0x80000004, 0x80000008 issued; if_pc_o follows in order.
REQ-038 if_ready_i=0 for 5 cycles in HOLD -> if_pc_o/if_instr_o stable, imem_req_o=0 throughout.
REQ-039 br_taken_i with target 0x1000 in WAIT, rvalid 2 cycles later -> response dropped, next imem_addr_o=0x1000, no if_valid_o for dropped instruction.
REQ-040 br_taken_i with gnt in same REQ cycle, target 0x2002 -> DROP, misalign_o pulse, next fetch 0x2000.
REQ-041 pc_q=64'hFFFF_FFFF_FFFF_FFFC granted -> next imem_addr_o=0.
REQ-042 rst_n low during WAIT -> outputs reset asynchronously, first fetch after release at RESET_PC.
